dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder: the memory end of the core's load/store port. Accepts one request
//   at a time over a valid/ready handshake, models LATENCY-cycle SRAM access, returns data.
// - Replaces the zero-latency combinational RAM behind the MEM stage.
// - Read data is right-justified and unextended; sign/zero extension stays in load_extend.
// PARAMETERS
// DATA_W     64            data/dword width in bits (fixed 64; byte lanes = 8)
// ADDR_W     64            request address width (matches ImmWidth)
// DEPTH      4096          backing store size in 64-bit dwords (power of 2)
// BASE_ADDR  'h80000000    byte address of dword 0
// LATENCY    2             cycles from accept to resp_valid; legal range 1..15
// PORTS
// clk         in   1       clock, all state on posedge
// rst         in   1       synchronous, active-high reset
// req_valid   in   1       request present
// req_ready   out  1       responder can accept (combinational: state==IDLE)
// req_wen     in   1       1=store, 0=load
// req_addr    in   ADDR_W  byte address
// req_wdata   in   DATA_W  store data, right-justified
// req_wdt     in   4       one-hot width: [0]=byte [1]=half [2]=word [3]=dword
// resp_valid  out  1       response present
// resp_ready  in   1       consumer takes response
// resp_rdata  out  DATA_W  load data right-justified, bits above width = 0; 0 for stores/errors
// resp_err    out  1       access faulted; no memory side effect
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 from
//   the first cycle after rst. Memory array is not cleared.
// - FSM IDLE->WAIT on req_valid&&req_ready: latch wen/addr/wdata/wdt; cnt<=LATENCY-1.
// - WAIT: cnt decrements each cycle. At the edge where cnt==0: commit store (or latch load
//   data) and go to RESP. req_valid accepted at edge N gives resp_valid high from edge N+LATENCY.
// - RESP: resp_valid=1; rdata/err held stable until resp_ready. RESP->IDLE on resp_ready.
//   At most one request outstanding; peak throughput 1 per LATENCY+1 cycles.
// - req_ready=0 in WAIT/RESP; req_valid there is ignored, not queued.
// - Index = (addr-BASE_ADDR)>>3; offset = addr[2:0].
// - Store: byte mask = width mask << offset; wdata << (8*offset) into the selected dword.
//   Other bytes are untouched.
// - Load: dword >> (8*offset), masked to width.
// - Out of range (addr<BASE_ADDR or addr>=BASE_ADDR+8*DEPTH): resp_err=1, rdata=0, no write.
//   Applies regardless of macro.
// - Store response: resp_valid pulses through RESP like a load; rdata=0.
// - rst during WAIT: request dropped, uncommitted store never written. rst during RESP:
//   response dropped. rst has priority over every transition.
// - resp_valid and resp_ready may both be high on the RESP exit cycle. req_ready rises the
//   next cycle (no same-cycle re-accept).
// CONFIGURATION
// DMEM_ALIGN_CHECK_EN defined:
//   - offset not a multiple of the access size, or req_wdt not one-hot: resp_err=1, rdata=0,
//     no write; timing unchanged.
// DMEM_ALIGN_CHECK_EN undefined:
//   - offset low bits are forced to natural alignment (half:[0], word:[1:0], dword:[2:0]).
//   - Non-one-hot req_wdt is treated as dword.
//   - resp_err only for out-of-range.
// TESTING (LATENCY=2, BASE_ADDR='h80000000)
// 1 Reset:
//   rst 1 cycle -> req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
// 2 Dword round trip:
//   - sd 'h1122334455667788 @'h80000008 accepted edge N -> resp_valid at N+2, err=0.
//   - ld @'h80000008 -> rdata='h1122334455667788.
// 3 Sub-word lanes:
//   - sb 'hAB @'h8000000B; ld @'h80000008 -> 'h11223344AB667788.
//   - lh @'h8000000A -> 'hAB66. lbu @'h8000000F -> 'h11.
// 4 Backpressure:
//   - resp_ready=0 for 5 cycles after resp_valid -> rdata/err stable, req_ready=0.
//   - A req_valid pulse in that window is not accepted. resp_ready=1 -> IDLE next cycle.
// 5 Faults:
//   - ld @'h7FFFFFF8 -> err=1, rdata=0.
//   - lw @'h80000002: with DMEM_ALIGN_CHECK_EN -> err=1; without -> word @'h80000000, err=0.
// 6 Reset mid-op:
//   sd 'hFFFF... @'h80000008, rst in WAIT -> ld @'h80000008 returns prior 'h11223344AB667788.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder. Serves one load or store at a time over
//               valid/ready, with LATENCY-cycle SRAM access and right-justified,
//               unextended load data. Define DMEM_ALIGN_CHECK_EN to fault
//               misaligned accesses instead of force-aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int                LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wdt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(8 * DEPTH);
    localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wdt_q, wdt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   addr_off;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [2:0]          off;
    logic [2:0]          eff_off;
    logic [7:0]          lane_mask;
    logic                misalign;
    logic                fault;
    logic [7:0]          byte_en;
    logic [DATA_W-1:0]   bit_mask;
    logic [DATA_W-1:0]   width_mask;
    logic [5:0]          shamt;
    logic [DATA_W-1:0]   cur_dword;
    logic [DATA_W-1:0]   wr_dword;
    logic [DATA_W-1:0]   ld_data;
    logic                commit;
    logic                mem_we;

    // Decode is taken from the latched request, so req_* may change freely after accept.
    assign addr_off = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (addr_off < SPAN);
    assign idx      = addr_off[IDX_W+2:3];
    assign off      = addr_q[2:0];

    always_comb begin
        lane_mask = 8'hFF;
        eff_off   = 3'd0;
        misalign  = 1'b0;
        unique case (wdt_q)
            4'b0001: begin
                lane_mask = 8'h01;
                eff_off   = off;
            end
            4'b0010: begin
                lane_mask = 8'h03;
                misalign  = ALIGN_CHECK && off[0];
                eff_off   = ALIGN_CHECK ? off : {off[2:1], 1'b0};
            end
            4'b0100: begin
                lane_mask = 8'h0F;
                misalign  = ALIGN_CHECK && (off[1:0] != 2'd0);
                eff_off   = ALIGN_CHECK ? off : {off[2], 2'b00};
            end
            4'b1000: begin
                misalign  = ALIGN_CHECK && (off != 3'd0);
            end
            default: begin
                misalign  = ALIGN_CHECK;
            end
        endcase
    end

    assign fault   = !in_range || misalign;
    assign byte_en = lane_mask << eff_off;
    assign shamt   = {eff_off, 3'b000};

    always_comb begin
        bit_mask   = '0;
        width_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8]   = {8{byte_en[i]}};
            width_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
    end

    assign cur_dword = mem[idx];
    assign wr_dword  = (cur_dword & ~bit_mask) | ((wdata_q << shamt) & bit_mask);
    assign ld_data   = (cur_dword >> shamt) & width_mask;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdt_d   = wdt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wdt_d   = req_wdt;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    err_d   = fault;
                    rdata_d = (fault || wen_q) ? '0 : ld_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_we = commit && wen_q && !fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wdt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdt_q   <= wdt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Backing store is never cleared; reset only blocks an uncommitted write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[idx] <= wr_dword;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Randomized scoreboard bench for dmem_responder against a
//               byte-addressed reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          LATENCY = 2;
    localparam int          DEPTH   = 4096;
    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam logic [63:0] SPAN    = 64'(8 * DEPTH);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_wdt = 4'b1000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] exp_q[$];
    logic [7:0]  mdl [longint unsigned];

    dmem_responder #(
        .DATA_W   (64),
        .ADDR_W   (64),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE),
        .LATENCY  (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wdt   (req_wdt),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory; access size from one-hot width.
    function automatic void model(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                                  input logic [3:0] wdt, output logic err, output logic [63:0] rdata);
        int size;
        longint unsigned a;
        err   = 1'b0;
        rdata = '0;
        case (wdt)
            4'b0001: size = 1;
            4'b0010: size = 2;
            4'b0100: size = 4;
            4'b1000: size = 8;
            default: size = 0;
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        if (size == 0 || (addr % size) != 0) err = 1'b1;
        a = addr;
`else
        if (size == 0) size = 8;
        a = addr - (addr % size);
`endif
        if (addr < BASE || addr >= BASE + SPAN) err = 1'b1;
        if (!err) begin
            for (int i = 0; i < size; i++) begin
                if (wen) mdl[a + i] = wdata[8*i +: 8];
                else     rdata[8*i +: 8] = mdl[a + i];
            end
        end
    endfunction

    // Monitor: every completed response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            logic [64:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got err=%0b rdata=%h expected no response", resp_err, resp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL resp: got err=%0b rdata=%h expected err=%0b rdata=%h",
                             resp_err, resp_rdata, e[64], e[63:0]);
                end
            end
        end
    end

    // Issues one request from posedge+1 and returns at posedge+1 after the response is taken.
    task automatic do_req(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [3:0] wdt, input int hold);
        logic        e_err;
        logic [63:0] e_data;
        int          k;
        model(wen, addr, wdata, wdt, e_err, e_data);
        exp_q.push_back({e_err, e_data});
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wdt   = wdt;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, LATENCY);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", resp_valid, 1);
            check("hold_req_ready", req_ready, 0);
            check("hold_data", {resp_err, resp_rdata}, {e_err, e_data});
            if (h == 0) begin
                req_wen   = 1'b1;
                req_addr  = BASE + 64'($urandom_range(0, 127));
                req_wdata = {$urandom, $urandom};
                req_wdt   = 4'b1000;
                req_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("exit_resp_valid", resp_valid, 0);
        check("exit_req_ready", req_ready, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a;
        logic [3:0]  w;
        int          sel;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);

        // Give the random window known contents.
        for (int i = 0; i < 16; i++) do_req(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 4'b1000, 0);

        do_req(1'b1, 64'h8000_0008, 64'h1122334455667788, 4'b1000, 0);
        do_req(1'b0, 64'h8000_0008, '0, 4'b1000, 0);
        do_req(1'b1, 64'h8000_000B, 64'hAB, 4'b0001, 0);
        do_req(1'b0, 64'h8000_0008, '0, 4'b1000, 0);
        do_req(1'b0, 64'h8000_000A, '0, 4'b0010, 0);
        do_req(1'b0, 64'h8000_000F, '0, 4'b0001, 0);
        do_req(1'b0, 64'h8000_0008, '0, 4'b1000, 5);
        do_req(1'b0, 64'h7FFF_FFF8, '0, 4'b1000, 0);
        do_req(1'b0, 64'h8000_0002, '0, 4'b0100, 0);
        do_req(1'b1, BASE + SPAN - 8, 64'hCAFE_F00D_1234_5678, 4'b1000, 0);
        do_req(1'b0, BASE + SPAN - 8, '0, 4'b1000, 0);
        do_req(1'b1, BASE + SPAN, 64'h5555, 4'b1000, 1);
        do_req(1'b0, BASE + SPAN, '0, 4'b1000, 0);

        // Reset while the store sits in WAIT: it must never land.
        req_wen   = 1'b1;
        req_addr  = 64'h8000_0008;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdt   = 4'b1000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_req_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_resp", resp_valid, 0);
            idle(1);
        end
        do_req(1'b0, 64'h8000_0008, '0, 4'b1000, 0);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 11);
            if (sel == 0)      a = BASE - 64'($urandom_range(1, 32));
            else if (sel == 1) a = BASE + SPAN + 64'($urandom_range(0, 63));
            else               a = BASE + 64'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) w = 4'($urandom);
            else                           w = 4'(1 << $urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, w, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
